axi_sram_responder: RTL and testbench

AXI3 slave (responder) that turns AXI read/write transactions into accesses on a single-port synchronous SRAM. It is the far end of the CPU-side AXI master adapters and backs the ROM/RAM AXI ports in simulation and FPGA builds. It handles one transaction at a time, INCR/FIXED bursts of 1–16 beats, 32-bit data.

---
 rtl/axi_sram_responder_pkg.sv | 22 ++
 rtl/axi_burst_addr_gen.sv | 49 ++++
 rtl/axi_sram_responder.sv | 192 +++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_sram_responder_pkg.sv
// Shared AXI3 encodings, bus widths and responder FSM states.
// Latency: n/a. Backpressure: n/a.
package axi_sram_responder_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int LEN_W  = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_RD_DATA,
        S_WR_DATA,
        S_WR_RESP
    } state_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst address/beat counter: holds the current beat address, remaining count and burst type.
// Latency: advances one beat per step pulse. Backpressure: none, the caller decides when to step.
module axi_burst_addr_gen
    import axi_sram_responder_pkg::*;
#(
    parameter int          MEM_AW    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic [1:0]        load_burst,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [MEM_AW-1:0] sram_addr,
    output logic              last,
    output logic              in_range
);
    logic [LEN_W-1:0]  count;
    logic              fixed;
    logic [ADDR_W-1:0] offset;
    logic              unused_offset;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr  <= '0;
            count <= '0;
            fixed <= 1'b0;
        end else if (load) begin
            addr  <= load_addr;
            count <= load_len;
            fixed <= (load_burst == BURST_FIXED);
        end else if (step) begin
            // INCR wraps naturally at 2^32; reserved burst codes behave as INCR
            if (!fixed) begin
                addr <= addr + 32'd4;
            end
            count <= count - LEN_W'(1);
        end
    end

    assign offset        = addr - BASE_ADDR;
    assign sram_addr     = offset[MEM_AW+1:2];
    assign in_range      = (offset[ADDR_W-1:MEM_AW+2] == '0);
    assign last          = (count == '0);
    assign unused_offset = ^offset[1:0];
endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 responder onto a single-port sync SRAM, one transaction at a time; AXI_RANGE_CHECK_EN adds range errors.
// Latency: first rvalid 3 cycles after AR handshake; writes one beat per cycle. Backpressure: R/B held until ready.
module axi_sram_responder
    import axi_sram_responder_pkg::*;
#(
    parameter int          MEM_AW    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   arid,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [LEN_W-1:0]  awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    output logic [ID_W-1:0]   rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    input  logic [ID_W-1:0]   wid,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    state_t            state, state_n;
    logic              grant_rd, grant_wr, step;
    logic              last_grant_wr, wr_err;
    logic              last, in_range, beat_ok, beat_err;
    logic [ADDR_W-1:0] addr_cur;
    logic              unused_inputs;

    axi_burst_addr_gen #(
        .MEM_AW    (MEM_AW),
        .BASE_ADDR (BASE_ADDR)
    ) u_agen (
        .clk        (clk),
        .rst        (rst),
        .load       (grant_rd | grant_wr),
        .load_addr  (grant_rd ? araddr  : awaddr),
        .load_len   (grant_rd ? arlen   : awlen),
        .load_burst (grant_rd ? arburst : awburst),
        .step       (step),
        .addr       (addr_cur),
        .sram_addr  (sram_addr),
        .last       (last),
        .in_range   (in_range)
    );

`ifdef AXI_RANGE_CHECK_EN
    assign beat_ok = in_range;
`else
    assign beat_ok = 1'b1;
`endif
    // A write beat is in error if it is out of range or its wlast disagrees with the beat count
    assign beat_err      = !beat_ok || (last != wlast);
    assign rvalid        = (state == S_RD_DATA);
    assign bvalid        = (state == S_WR_RESP);
    assign sram_wdata    = wdata;
    assign unused_inputs = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot,
                             wid, addr_cur, in_range};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        arready  = 1'b0;
        awready  = 1'b0;
        wready   = 1'b0;
        sram_en  = 1'b0;
        sram_we  = 4'h0;
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        step     = 1'b0;
        case (state)
            S_IDLE: begin
                // On a tie, read wins only if write was granted last time
                if (!rst) begin
                    if (arvalid && (!awvalid || last_grant_wr)) begin
                        arready  = 1'b1;
                        grant_rd = 1'b1;
                        state_n  = S_RD_REQ;
                    end else if (awvalid) begin
                        awready  = 1'b1;
                        grant_wr = 1'b1;
                        state_n  = S_WR_DATA;
                    end
                end
            end
            S_RD_REQ: begin
                sram_en = beat_ok;
                state_n = S_RD_WAIT;
            end
            S_RD_WAIT: state_n = S_RD_DATA;
            S_RD_DATA: begin
                if (rready) begin
                    if (rlast) begin
                        state_n = S_IDLE;
                    end else begin
                        step    = 1'b1;
                        state_n = S_RD_REQ;
                    end
                end
            end
            S_WR_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    sram_en = beat_ok;
                    sram_we = beat_ok ? wstrb : 4'h0;
                    step    = 1'b1;
                    if (last || wlast) begin
                        state_n = S_WR_RESP;
                    end
                end
            end
            S_WR_RESP: begin
                if (bready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rid           <= '0;
            bid           <= '0;
            rdata         <= '0;
            rresp         <= RESP_OKAY;
            rlast         <= 1'b0;
            bresp         <= RESP_OKAY;
            wr_err        <= 1'b0;
            last_grant_wr <= 1'b1;
        end else begin
            if (grant_rd) begin
                rid           <= arid;
                last_grant_wr <= 1'b0;
            end
            if (grant_wr) begin
                bid           <= awid;
                wr_err        <= 1'b0;
                last_grant_wr <= 1'b1;
            end
            if (state == S_RD_WAIT) begin
                rdata <= beat_ok ? sram_rdata : '0;
                rresp <= beat_ok ? RESP_OKAY : RESP_SLVERR;
                rlast <= last;
            end
            if (state == S_WR_DATA && wvalid) begin
                if (last || wlast) begin
                    bresp <= (wr_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
                end else begin
                    wr_err <= wr_err || beat_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_sram_responder.sv
// Bench for axi_sram_responder: directed vector table, hand sequences and random bursts vs a word-array model.
// Latency: n/a. Backpressure: R stalls driven from the vector table and random stimulus.
module tb_axi_sram_responder;
    import axi_sram_responder_pkg::*;

    localparam int          MEM_AW = 16;
    localparam logic [31:0] BASE   = 32'h0000_0000;
`ifdef AXI_RANGE_CHECK_EN
    localparam bit RNG = 1'b1;
`else
    localparam bit RNG = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata, sram_wdata, sram_rdata = '0;
    logic [3:0]  arlen = '0, awlen = '0, wstrb = '0, sram_we;
    logic [2:0]  arsize = 3'd2, awsize = 3'd2, arprot = '0, awprot = '0;
    logic [1:0]  arburst = '0, awburst = '0, arlock = '0, awlock = '0, rresp, bresp;
    logic [3:0]  arcache = '0, awcache = '0;
    logic        arvalid = 0, awvalid = 0, wvalid = 0, wlast = 0, rready = 0, bready = 0;
    logic        arready, awready, rvalid, rlast, wready, bvalid, sram_en;
    logic [MEM_AW-1:0] sram_addr;

    axi_sram_responder #(.MEM_AW(MEM_AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM behavioural model (environment) and the independent reference image
    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    logic [31:0] mw;
    int          en_count = 0;
    always @(posedge clk) begin
        if (sram_en === 1'b1) begin
            en_count <= en_count + 1;
            if (sram_we == 4'h0) begin
                sram_rdata <= mem[sram_addr];
            end else begin
                mw = mem[sram_addr];
                for (int i = 0; i < 4; i++) if (sram_we[i]) mw[8*i +: 8] = sram_wdata[8*i +: 8];
                mem[sram_addr] <= mw;
            end
        end
    end

    int          n_cmp = 0, n_fail = 0;
    logic [31:0] wd [0:15];
    logic [3:0]  ws [0:15];
    logic [31:0] last_rdata;
    logic [1:0]  last_rresp, last_bresp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit inr(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o < (32'd4 << MEM_AW);
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return int'(o[MEM_AW+1:2]);
    endfunction

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a : a + 32'd4;
    endfunction

    task automatic reset_check();
        chk("rst_arready", arready, 0); chk("rst_awready", awready, 0);
        chk("rst_rvalid", rvalid, 0);   chk("rst_rlast", rlast, 0);
        chk("rst_wready", wready, 0);   chk("rst_bvalid", bvalid, 0);
        chk("rst_sram_en", sram_en, 0); chk("rst_sram_we", sram_we, 0);
        chk("rst_rid", rid, 0);         chk("rst_bid", bid, 0);
        chk("rst_rresp", rresp, 0);     chk("rst_bresp", bresp, 0);
        chk("rst_rdata", rdata, 0);
    endtask

    task automatic rd_data(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int stall);
        logic [31:0] a, ed;
        logic [1:0]  er;
        bit          ok;
        int          n;
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!rvalid && n < 40);
            if (b == 0) chk("rd_latency", n, 3);
            ok = !RNG || inr(a);
            ed = ok ? ref_mem[widx(a)] : 32'h0;
            er = ok ? RESP_OKAY : RESP_SLVERR;
            chk("rd_valid", rvalid, 1); chk("rd_data", rdata, ed);
            chk("rd_id", rid, id);      chk("rd_resp", rresp, er);
            chk("rd_last", rlast, b == int'(len));
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                chk("rd_stable", {rvalid, rlast, rdata}, {1'b1, b == int'(len), ed});
            end
            last_rdata = rdata;
            last_rresp = rresp;
            rready = 1'b1;
            @(posedge clk); #1 rready = 1'b0;
            a = nxt(a, burst);
        end
        @(negedge clk);
        chk("rd_done", rvalid, 0);
    endtask

    task automatic wr_data(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input int nbeats);
        logic [31:0] a;
        int          acc, n;
        bit          err;
        a   = addr;
        acc = (nbeats < int'(len) + 1) ? nbeats : int'(len) + 1;
        err = (nbeats != int'(len) + 1);
        for (int b = 0; b < acc; b++) begin
            @(negedge clk);
            wvalid = 1'b1; wdata = wd[b]; wstrb = ws[b]; wlast = (b == nbeats - 1);
            #1;
            n = 0;
            while (!wready && n < 40) begin @(negedge clk); #1; n++; end
            chk("wr_ready", wready, 1);
            if (!RNG || inr(a)) begin
                for (int k = 0; k < 4; k++) if (ws[b][k]) ref_mem[widx(a)][8*k +: 8] = wd[b][8*k +: 8];
            end else begin
                err = 1'b1;
            end
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
            a = nxt(a, burst);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!bvalid && n < 40);
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bid", bid, id);
        chk("wr_bresp", bresp, err ? RESP_SLVERR : RESP_OKAY);
        last_bresp = bresp;
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        chk("wr_done", bvalid, 0);
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int stall);
        int n;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 40) begin @(negedge clk); #1; n++; end
        chk("ar_ready", arready, 1);
        @(posedge clk); #1 arvalid = 1'b0;
        rd_data(id, addr, len, burst, stall);
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input int nbeats);
        int n;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
        #1;
        n = 0;
        while (!awready && n < 40) begin @(negedge clk); #1; n++; end
        chk("aw_ready", awready, 1);
        @(posedge clk); #1 awvalid = 1'b0;
        wr_data(id, addr, len, burst, nbeats);
    endtask

    task automatic arb_pair(input bit exp_rd);
        int n;
        wd[0] = 32'hA5A5_0000 | 32'(exp_rd); ws[0] = 4'hF;
        @(negedge clk);
        arid = 4'h6; araddr = 32'h40; arlen = 4'd0; arburst = BURST_INCR; arvalid = 1'b1;
        awid = 4'h9; awaddr = 32'h80; awlen = 4'd0; awburst = BURST_INCR; awvalid = 1'b1;
        #1;
        chk("arb_arready", arready, exp_rd);
        chk("arb_awready", awready, !exp_rd);
        @(posedge clk); #1;
        n = 0;
        if (exp_rd) begin
            arvalid = 1'b0;
            rd_data(4'h6, 32'h40, 4'd0, BURST_INCR, 0);
            while (!awready && n < 40) begin @(negedge clk); #1; n++; end
            chk("arb_aw_next", awready, 1);
            @(posedge clk); #1 awvalid = 1'b0;
            wr_data(4'h9, 32'h80, 4'd0, BURST_INCR, 1);
        end else begin
            awvalid = 1'b0;
            wr_data(4'h9, 32'h80, 4'd0, BURST_INCR, 1);
            while (!arready && n < 40) begin @(negedge clk); #1; n++; end
            chk("arb_ar_next", arready, 1);
            @(posedge clk); #1 arvalid = 1'b0;
            rd_data(4'h6, 32'h40, 4'd0, BURST_INCR, 0);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        int          nb;
        logic [31:0] d0;
        logic [3:0]  strb;
        int          stall;
        logic [1:0]  resp;
    } vec_t;

    vec_t vt [0:10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n, r, nb, stall;
        logic [31:0] a;
        logic [3:0]  len;
        logic [1:0]  burst;

        vt[0]  = '{1'b1, 4'h5, 32'h100, 4'd3, BURST_INCR,  4, 32'h1,        4'hF, 0, RESP_OKAY};
        vt[1]  = '{1'b0, 4'h3, 32'h100, 4'd3, BURST_INCR,  0, 32'h0,        4'h0, 0, RESP_OKAY};
        vt[2]  = '{1'b1, 4'h2, 32'h200, 4'd3, BURST_INCR,  2, 32'h20,       4'hF, 0, RESP_SLVERR};
        vt[3]  = '{1'b0, 4'h7, 32'h200, 4'd3, BURST_INCR,  0, 32'h0,        4'h0, 1, RESP_OKAY};
        vt[4]  = '{1'b1, 4'h4, 32'h300, 4'd1, BURST_INCR,  3, 32'h30,       4'hF, 0, RESP_SLVERR};
        vt[5]  = '{1'b0, 4'h8, 32'h300, 4'd1, 2'b10,       0, 32'h0,        4'h0, 0, RESP_OKAY};
        vt[6]  = '{1'b1, 4'h9, 32'h400, 4'd2, BURST_FIXED, 3, 32'h40,       4'h3, 0, RESP_OKAY};
        vt[7]  = '{1'b0, 4'hA, 32'h400, 4'd2, BURST_FIXED, 0, 32'h0,        4'h0, 0, RESP_OKAY};
        vt[8]  = '{1'b1, 4'hB, 32'h500, 4'd0, 2'b11,       1, 32'hCAFEF00D, 4'hF, 0, RESP_OKAY};
        vt[9]  = '{1'b0, 4'hC, 32'h4FC, 4'd2, 2'b11,       0, 32'h0,        4'h0, 2, RESP_OKAY};
        vt[10] = '{1'b0, 4'hD, 32'h100, 4'd3, BURST_INCR,  0, 32'h0,        4'h0, 5, RESP_OKAY};

        for (int i = 0; i < 65536; i++) begin
            mem[i] = 32'h0; ref_mem[i] = 32'h0;
        end
        mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;

        #1 reset_check();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        arb_pair(1'b1);
        axi_read(4'h3, 32'h40, 4'd0, BURST_INCR, 0);
        chk("single_rdata", last_rdata, 32'hDEADBEEF);
        arb_pair(1'b0);

        for (int i = 0; i <= 10; i++) begin
            if (vt[i].wr) begin
                for (int b = 0; b < 16; b++) begin wd[b] = vt[i].d0 + b; ws[b] = vt[i].strb; end
                axi_write(vt[i].id, vt[i].addr, vt[i].len, vt[i].burst, vt[i].nb);
                chk("vec_bresp", last_bresp, vt[i].resp);
            end else begin
                axi_read(vt[i].id, vt[i].addr, vt[i].len, vt[i].burst, vt[i].stall);
                chk("vec_rresp", last_rresp, vt[i].resp);
            end
        end
        chk("bp_last_rdata", last_rdata, 32'd4);

        wd[0] = 32'h0000_00AA; ws[0] = 4'b0001;
        wd[1] = 32'h00BB_0000; ws[1] = 4'b0100;
        axi_write(4'h1, 32'h8, 4'd1, BURST_FIXED, 2);
        axi_read(4'h1, 32'h8, 4'd0, BURST_INCR, 0);
        chk("fixed_strb_word", last_rdata, 32'h00BB00AA);

        // Reset asserted asynchronously while a read burst is mid-flight
        @(negedge clk);
        arid = 4'h2; araddr = 32'h100; arlen = 4'd7; arburst = BURST_INCR; arvalid = 1'b1;
        #1;
        n = 0;
        while (!arready && n < 40) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1 arvalid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 40);
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rvalid && n < 40);
        chk("mid_rvalid", rvalid, 1);
        #2 rst = 1'b1;
        #1 reset_check();
        @(negedge clk) rst = 1'b0;
        rready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", {rvalid, bvalid}, 2'b00);
        end
        rready = 1'b0;
        axi_read(4'h4, 32'h100, 4'd3, BURST_INCR, 0);

`ifdef AXI_RANGE_CHECK_EN
        n = en_count;
        axi_read(4'h1, BASE + 32'h0004_0000, 4'd0, BURST_INCR, 0);
        chk("rng_rresp", last_rresp, RESP_SLVERR);
        chk("rng_rdata", last_rdata, 32'h0);
        chk("rng_no_sram_rd", en_count - n, 0);
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        n = en_count;
        axi_write(4'h1, BASE + 32'h0004_0010, 4'd0, BURST_INCR, 1);
        chk("rng_bresp", last_bresp, RESP_SLVERR);
        chk("rng_no_sram_wr", en_count - n, 0);
`endif

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 1023)) << 2;
            else if (r < 8)  a = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
            else             a = 32'h0004_0000 + (32'($urandom_range(0, 7)) << 2);
            len   = 4'($urandom_range(0, 7));
            burst = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, int'(len) + 2) : int'(len) + 1;
                for (int b = 0; b < 16; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
                axi_write(4'($urandom), a, len, burst, nb);
            end else begin
                stall = $urandom_range(0, 2);
                axi_read(4'($urandom), a, len, burst, stall);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
